change_dispenser: RTL



---
 rtl/change_dispenser_if.sv | 26 ++
 rtl/change_dispenser.sv | 96 +++++++++
 2 files changed

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request, refill, coin-eject and status signals of the change dispenser.
interface change_dispenser_if;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_change;
    logic       refill;
    logic [1:0] refill_type;
    logic [3:0] refill_amount;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       coin_ready;
    logic       done;
    logic       short_err;
    logic [6:0] remaining;
    logic       busy;

    modport slave (
        input  req_valid, req_change, refill, refill_type, refill_amount, coin_ready,
        output req_ready, coin_valid, coin_type, done, short_err, remaining, busy
    );

    modport master (
        output req_valid, req_change, refill, refill_type, refill_amount, coin_ready,
        input  req_ready, coin_valid, coin_type, done, short_err, remaining, busy
    );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout (20/10/5/1) from a per-denomination inventory.
// Define CHANGE_DISPENSER_TIMEOUT_EN to abort a coin the ejector never acknowledges.
module change_dispenser #(
    parameter int INV_W    = 4,
    parameter int INIT_CNT = 4,
    parameter int TIMEOUT  = 15
) (
    input logic clk,
    input logic rst,
    change_dispenser_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0, SELECT = 3'd1, ISSUE = 3'd2, DONE = 3'd3, ERR = 3'd4;
    localparam int SW = (INV_W > 4 ? INV_W : 4) + 1;
    localparam logic [INV_W-1:0] CMAX = '1;

    function automatic logic [6:0] coin_val(input logic [1:0] t);
        return t == 2'd3 ? 7'd20 : t == 2'd2 ? 7'd10 : t == 2'd1 ? 7'd5 : 7'd1;
    endfunction

    logic [2:0] state_q, state_d;
    logic [6:0] rem_q, rem_d;
    logic [1:0] type_q, type_d;
    logic [3:0][INV_W-1:0] cnt_q, cnt_d;
    logic [3:0] avail;
    logic [1:0] pick;
    logic [SW-1:0] sum;
    logic timeout;

    always_comb begin
        for (int i = 0; i < 4; i++) avail[i] = coin_val(2'(i)) <= rem_q && cnt_q[i] != '0;
        pick = avail[3] ? 2'd3 : avail[2] ? 2'd2 : avail[1] ? 2'd1 : 2'd0;
        sum = SW'(cnt_q[bus.refill_type]) + SW'(bus.refill_amount);
    end

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_q, to_d;
    always_comb begin
        to_d = state_q == ISSUE && !bus.coin_ready ? to_q + 1'b1 : '0;
        timeout = to_q == TW'(TIMEOUT - 1);
    end
    always_ff @(posedge clk) to_q <= rst ? '0 : to_d;
`else
    assign timeout = TIMEOUT < 0;
`endif

    always_comb begin
        state_d = state_q;
        rem_d = rem_q;
        type_d = type_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.refill) cnt_d[bus.refill_type] = sum > SW'(CMAX) ? CMAX : sum[INV_W-1:0];
                if (bus.req_valid) begin
                    rem_d = bus.req_change;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                type_d = avail != '0 ? pick : type_q;
                state_d = rem_q == '0 ? DONE : avail != '0 ? ISSUE : ERR;
            end
            ISSUE: begin
                if (bus.coin_ready) begin
                    cnt_d[type_q] = cnt_q[type_q] - 1'b1;
                    rem_d = rem_q - coin_val(type_q);
                    state_d = SELECT;
                end else if (timeout) state_d = ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q <= '0;
            type_q <= '0;
            cnt_q <= {4{INV_W'(INIT_CNT)}};
        end else begin
            state_q <= state_d;
            rem_q <= rem_d;
            type_q <= type_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.req_ready = state_q == IDLE;
    assign bus.busy = state_q != IDLE;
    assign bus.coin_valid = state_q == ISSUE;
    assign bus.coin_type = type_q;
    assign bus.done = state_q == DONE;
    assign bus.short_err = state_q == ERR;
    assign bus.remaining = rem_q;
endmodule
